// File: rtl/d_cache_pkg.sv
// d_cache_pkg: FSM encoding and address-map constants shared by the 2-way data cache.
package d_cache_pkg;
    typedef enum logic {IDLE, REFILL} state_t;
    localparam logic [2:0] UNCACHED_SEG = 3'b101;
endpackage

// File: rtl/d_cache_2way_if.sv
// d_cache_2way_if: single-word request/ready bus used on both the CPU and memory sides.
interface d_cache_2way_if #(parameter int A_WIDTH = 32);
    logic [A_WIDTH-1:0] a;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [3:0]         wen;
    logic               strobe;
    logic               rw;
    logic               ready;
    modport master (output a, wdata, wen, strobe, rw, input rdata, ready);
    modport slave  (input a, wdata, wen, strobe, rw, output rdata, ready);
endinterface

// File: rtl/d_cache_way.sv
// d_cache_way: one way's valid/tag/data arrays; combinational read, byte-enable word write.
module d_cache_way #(
    parameter int T_WIDTH  = 22,
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [C_INDEX-1:0]  rd_idx,
    input  logic [C_OFFSET-1:0] rd_word,
    output logic                valid,
    output logic [T_WIDTH-1:0]  tag,
    output logic [31:0]         data,
    input  logic [3:0]          we,
    input  logic [C_INDEX-1:0]  w_idx,
    input  logic [C_OFFSET-1:0] w_word,
    input  logic [31:0]         w_data,
    input  logic                inval,
    input  logic                set_valid,
    input  logic [T_WIDTH-1:0]  w_tag
);
    logic [2**C_INDEX-1:0] valids;
    logic [T_WIDTH-1:0]    tags  [2**C_INDEX];
    logic [31:0]           words [2**(C_INDEX+C_OFFSET)];

    assign valid = valids[rd_idx];
    assign tag   = tags[rd_idx];
    assign data  = words[{rd_idx, rd_word}];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) valids <= '0;
        else if (inval) valids[w_idx] <= 1'b0;
        else if (set_valid) valids[w_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (set_valid) tags[w_idx] <= w_tag;
        for (int i = 0; i < 4; i++)
            if (we[i]) words[{w_idx, w_word}][8*i +: 8] <= w_data[8*i +: 8];
    end
endmodule

// File: rtl/d_cache_2way.sv
// d_cache_2way: 2-way LRU write-through, no-write-allocate data cache with burst line refill.
module d_cache_2way
    import d_cache_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic             clk,
    input  logic             clrn,
    d_cache_2way_if.slave    cpu,
    d_cache_2way_if.master   mem
);
    localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;

    state_t                state, nxt;
    logic [T_WIDTH-1:0]    tag, ref_tag;
    logic [C_INDEX-1:0]    index, ref_idx, w_idx;
    logic [C_OFFSET-1:0]   word, cnt, nxt_cnt, w_word;
    logic [2**C_INDEX-1:0] lru;
    logic                  victim, nxt_victim, uncached, hit0, hit1;
    logic                  lru_we, lru_val, m_strobe, p_ready;
    logic [31:0]           w_data;
    logic                  v [2];
    logic                  inval [2];
    logic                  setv [2];
    logic [T_WIDTH-1:0]    t [2];
    logic [31:0]           d [2];
    logic [3:0]            we [2];

    assign {tag, index, word} = cpu.a[A_WIDTH-1:2];
    assign uncached = cpu.a[A_WIDTH-1 -: 3] == UNCACHED_SEG;
    assign hit0     = v[0] && t[0] == tag;
    assign hit1     = v[1] && t[1] == tag && !hit0;
    // During a refill the way writes follow the latched miss address, not the live CPU port.
    assign w_idx    = state == REFILL ? ref_idx : index;
    assign w_word   = state == REFILL ? cnt : word;
    assign w_data   = state == REFILL ? mem.rdata : cpu.wdata;
    assign mem.wdata  = cpu.wdata;
    assign mem.strobe = m_strobe && clrn;
    assign cpu.ready  = p_ready && clrn;

    for (genvar w = 0; w < 2; w++) begin : g_way
        d_cache_way #(.T_WIDTH(T_WIDTH), .C_INDEX(C_INDEX), .C_OFFSET(C_OFFSET)) u_way (
            .clk(clk), .clrn(clrn), .rd_idx(index), .rd_word(word),
            .valid(v[w]), .tag(t[w]), .data(d[w]), .we(we[w]),
            .w_idx(w_idx), .w_word(w_word), .w_data(w_data),
            .inval(inval[w]), .set_valid(setv[w]), .w_tag(ref_tag)
        );
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            victim  <= 1'b0;
            lru     <= '0;
            ref_tag <= '0;
            ref_idx <= '0;
        end else begin
            state  <= nxt;
            cnt    <= nxt_cnt;
            victim <= nxt_victim;
            if (state == IDLE) begin
                ref_tag <= tag;
                ref_idx <= index;
            end
            if (lru_we) lru[w_idx] <= lru_val;
        end
    end

    always_comb begin
        nxt        = state;
        nxt_cnt    = cnt;
        nxt_victim = victim;
        we[0]      = '0;
        we[1]      = '0;
        inval[0]   = 1'b0;
        inval[1]   = 1'b0;
        setv[0]    = 1'b0;
        setv[1]    = 1'b0;
        lru_we     = 1'b0;
        lru_val    = 1'b0;
        m_strobe   = 1'b0;
        p_ready    = 1'b0;
        mem.a      = cpu.a;
        mem.rw     = cpu.rw;
        mem.wen    = cpu.wen;
        cpu.rdata  = hit1 ? d[1] : d[0];
        if (state == REFILL) begin
            m_strobe = 1'b1;
            mem.rw   = 1'b0;
            mem.wen  = 4'hf;
            mem.a    = {ref_tag, ref_idx, cnt, 2'b00};
            if (mem.ready) begin
                we[victim] = 4'hf;
                nxt_cnt    = cnt + 1'b1;
                if (&cnt) begin
                    setv[victim] = 1'b1;
                    lru_we       = 1'b1;
                    lru_val      = !victim;
                    nxt          = IDLE;
                end
            end
        end else if (cpu.strobe) begin
            if (uncached) begin
                m_strobe  = 1'b1;
                p_ready   = mem.ready;
                cpu.rdata = mem.rdata;
            end else if (cpu.rw) begin
                m_strobe = 1'b1;
                p_ready  = mem.ready;
                if (mem.ready && (hit0 || hit1)) begin
                    we[hit1] = cpu.wen;
                    lru_we   = 1'b1;
                    lru_val  = !hit1;
                end
            end else if (hit0 || hit1) begin
                p_ready = 1'b1;
                lru_we  = 1'b1;
                lru_val = !hit1;
            end else begin
                nxt        = REFILL;
                nxt_victim = !v[0] ? 1'b0 : !v[1] ? 1'b1 : lru[index];
                inval[nxt_victim] = 1'b1;
            end
        end
    end
endmodule
